pipeline_skid_stage: RTL

//  Parametrised elastic pipeline register that replaces the fixed fetch/decode latch.

---
 rtl/pipeline_skid_stage_pkg.sv | 11 +
 rtl/pipeline_skid_stage_if.sv | 24 ++
 rtl/pipeline_skid_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipeline_skid_stage_pkg.sv
// Shared types for the elastic skid pipeline stage.
package pipeline_skid_stage_pkg;

   // The state encoding is the number of held entries, so occupancy is simply the state.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

endpackage

// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The upstream side is the producer and the downstream side is the consumer.
interface pipeline_skid_stage_if #(
   parameter int DATA_W = 64
);
   logic              up_valid;
   logic [DATA_W-1:0] up_data;
   logic              up_ready;
   logic              dn_valid;
   logic [DATA_W-1:0] dn_data;
   logic              dn_ready;

   // The stage itself: it accepts from upstream and offers downstream.
   modport slave (
      input  up_valid, up_data, dn_ready,
      output up_ready, dn_valid, dn_data
   );

   // The surrounding stages, or a bench, drive the stage from this side.
   modport master (
      output up_valid, up_data, dn_ready,
      input  up_ready, dn_valid, dn_data
   );
endinterface

// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register with a one-entry skid buffer.
// Every output is a flop, so dn_ready has no combinational path to up_ready.
// A downstream stall reaches upstream one cycle late, and the skid entry absorbs
// the word that is already in flight during that cycle.
module pipeline_skid_stage
   import pipeline_skid_stage_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int                CNT_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   pipeline_skid_stage_if.slave       bus,
   output logic [1:0]                 occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);

   skid_state_t       state;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic              up_ready_q;
   logic              dn_valid_q;
   logic              up_xfer;
   logic              dn_xfer;

   assign up_xfer      = bus.up_valid & up_ready_q;
   assign dn_xfer      = dn_valid_q & bus.dn_ready;
   assign bus.up_ready = up_ready_q;
   assign bus.dn_valid = dn_valid_q;
   assign bus.dn_data  = main_data;
   assign occupancy    = state;

   // Occupancy FSM. Flush squashes everything, but a dn_xfer in the same cycle has already
   // been delivered. The skid entry keeps its stale value because occupancy says whether it is live.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state      <= SKID_EMPTY;
         main_data  <= NOP_VALUE;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
      end else begin
         case (state)
            SKID_EMPTY: begin
               if (up_xfer) begin
                  state      <= SKID_ONE;
                  main_data  <= bus.up_data;
                  dn_valid_q <= 1'b1;
               end
            end
            SKID_ONE: begin
               if (up_xfer && dn_xfer) begin
                  main_data <= bus.up_data;
               end else if (up_xfer) begin
                  state      <= SKID_TWO;
                  skid_data  <= bus.up_data;
                  up_ready_q <= 1'b0;
               end else if (dn_xfer) begin
                  state      <= SKID_EMPTY;
                  main_data  <= NOP_VALUE;
                  dn_valid_q <= 1'b0;
               end
            end
            SKID_TWO: begin
               if (dn_xfer) begin
                  state      <= SKID_ONE;
                  main_data  <= skid_data;
                  up_ready_q <= 1'b1;
               end
            end
            default: begin
               state      <= SKID_EMPTY;
               main_data  <= NOP_VALUE;
               up_ready_q <= 1'b1;
               dn_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Backpressure counter. It saturates instead of wrapping, and only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (dn_valid_q && !bus.dn_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_up_data_known: assert property (@(posedge clk) disable iff (!rst_n)
      bus.up_valid |-> !$isunknown(bus.up_data));
   a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
      occupancy != 2'd3);
   a_no_xfer_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(up_xfer && (state == SKID_TWO)));
`endif

endmodule
